// File: rtl/mcp4911_spi_tx.sv
// mcp4911_spi_tx: a 4-deep sample FIFO feeding 16-bit SPI write frames to an
// MCP4911 10-bit DAC. Each frame is followed by a chip-select release
// half-period and an LDAC strobe half-period.
//
// Handshake (data_valid/data_ready): a sample transfers on every rising edge
// where both are high. data_ready depends only on FIFO occupancy and never on
// data_valid. The upstream side may change data_in freely while data_valid is low.
module mcp4911_spi_tx #(
  parameter int unsigned CLK_DIV = 25,
  parameter logic        BUF     = 1'b0,
  parameter logic        GA_N    = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       SCK,
  output logic       DAC_CS,
  output logic       DAC_SDI,
  output logic       DAC_LD,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CSHI  = 3'd3,
    LDAC  = 3'd4
  } state_t;

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // FIFO storage and bookkeeping
  logic [9:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       push, pop;

  // Serializer state
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    fall_q, fall_d;
  logic          done_q, done_d;
  logic          tick;

  assign data_ready = (count_q != 3'd4);
  assign push       = data_valid && data_ready;
  // Pop only from IDLE; a sample written this edge is not visible until the next.
  assign pop        = (state_q == IDLE) && (count_q != 3'd0);
  assign tick       = (cnt_q == CW'(CLK_DIV - 1));

  // Sample storage; no reset needed because occupancy gates every read.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
    end
  end

  // Serializer state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      shreg_q <= 16'h0000;
      fall_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      shreg_q <= shreg_d;
      fall_q  <= fall_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: half-period counter, SCK toggling and bit advance on falling edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    sck_d   = sck_q;
    shreg_d = shreg_q;
    fall_d  = fall_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d = {1'b0, BUF, GA_N, 1'b1, mem_q[rd_ptr_q], 2'b00};
          fall_d  = 4'd0;
          sck_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling edge: the 16th ends the frame, earlier ones expose the next bit.
            if (fall_q == 4'd15) begin
              state_d = CSHI;
            end else begin
              shreg_d = {shreg_q[14:0], 1'b0};
              fall_d  = fall_q + 4'd1;
            end
          end
        end
      end
      CSHI: begin
        if (tick) state_d = LDAC;
      end
      LDAC: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset drives them idle at once.
  assign SCK         = sck_q;
  assign DAC_CS      = !(state_q == LOAD || state_q == SHIFT);
  assign DAC_SDI     = (state_q == LOAD || state_q == SHIFT) ? shreg_q[15] : 1'b0;
  assign DAC_LD      = (state_q != LDAC);
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mcp4911_spi_tx.sv
// Bench for mcp4911_spi_tx: two instances (divider 25 with default gain/buffer
// bits, divider 2 with both bits flipped) checked every cycle against a
// frame-timeline model, plus a serial scoreboard and literal expectations.
`timescale 1ns/1ps
module tb_mcp4911_spi_tx;
  localparam int NL   = 2;
  localparam int MAXF = 64;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int cyc    = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0]    din [NL];
  logic [NL-1:0] dv, rdy, sck, cs, sdi, ld, bsy, fdone;
  logic [2:0]    dbg [NL];

  // Per-lane observations recorded by the capture processes
  logic [15:0] got_a  [NL][MAXF];
  int          rise_a [NL][MAXF];
  int          ld_a   [NL][MAXF];
  int          dur_a  [NL][MAXF];
  int          dn_a   [NL][MAXF];
  int          st_a   [NL][MAXF];
  int          got_n  [NL];
  int          dn_n   [NL];
  int          st_n   [NL];
  int          rises_a[NL];
  int          pend_n [NL];

  // clock / reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] frame_of(input logic b, input logic g, input logic [9:0] d);
    return {1'b0, b, g, 1'b1, d, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int   D  = (g == 0) ? 25 : 2;
    localparam logic PB = (g == 0) ? 1'b0 : 1'b1;
    localparam logic PG = (g == 0) ? 1'b1 : 1'b0;

    mcp4911_spi_tx #(.CLK_DIV(D), .BUF(PB), .GA_N(PG)) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .data_in    (din[g]),
      .data_valid (dv[g]),
      .data_ready (rdy[g]),
      .SCK        (sck[g]),
      .DAC_CS     (cs[g]),
      .DAC_SDI    (sdi[g]),
      .DAC_LD     (ld[g]),
      .busy       (bsy[g]),
      .frame_done (fdone[g]),
      .dbg_state_o(dbg[g])
    );

    // Model: FIFO contents, and position (cycles since leaving IDLE) in the current frame
    logic [9:0]  m_fifo [$];
    logic [15:0] exp_q  [$];
    bit          m_act   = 1'b0;
    bit          m_done  = 1'b0;
    int          m_off   = 0;
    logic [15:0] m_frame = 16'h0000;

    initial begin : model_p
      bit push_ok, pop_ok;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_fifo.delete();
          exp_q.delete();
          m_act  = 1'b0;
          m_done = 1'b0;
          m_off  = 0;
        end else begin
          push_ok = dv[g] && (m_fifo.size() < 4);
          pop_ok  = !m_act && (m_fifo.size() != 0);
          m_done  = 1'b0;
          if (m_act) begin
            m_off++;
            if (m_off == 35 * D) begin
              m_act  = 1'b0;
              m_done = 1'b1;
            end
          end else if (pop_ok) begin
            m_frame = frame_of(PB, PG, m_fifo.pop_front());
            m_act   = 1'b1;
            m_off   = 0;
          end
          if (push_ok) begin
            m_fifo.push_back(din[g]);
            exp_q.push_back(frame_of(PB, PG, din[g]));
          end
        end
      end
    end

    // Compare: every cycle, outputs {ready,busy,sck,cs,sdi,ld,done} from the frame timeline
    initial begin : cmp_p
      logic [6:0] e, a;
      int h;
      forever begin
        @(negedge clk);
        e = {(m_fifo.size() < 4), m_act, 1'b0, 1'b1, 1'b0, 1'b1, m_done};
        if (m_act) begin
          h = m_off / D;
          if (h <= 32) begin
            e[3] = 1'b0;
            e[4] = (h >= 2) && (h % 2 == 0);
            e[2] = (h == 0) ? m_frame[15] : m_frame[15 - (h - 1) / 2];
          end else if (h == 34) begin
            e[1] = 1'b0;
          end
        end
        a = {rdy[g], bsy[g], sck[g], cs[g], sdi[g], ld[g], fdone[g]};
        checks++;
        if (a !== e) begin
          errors++;
          if (nprint < 20)
            $display("FAIL lane%0d cycle_model t=%0t: got rdy,busy,sck,cs,sdi,ld,done=%b expected %b (state %0d)",
                     g, $time, a, e, dbg[g]);
          nprint++;
        end
      end
    end

    // Capture: rebuild frames from SDI at SCK rising edges, protocol rules, timing records
    initial begin : cap_p
      logic p_sck, p_cs;
      logic [15:0] cap, ef;
      int ld_len, t_start;
      p_sck = 1'b0; p_cs = 1'b1; cap = 16'h0000; ld_len = 0; t_start = 0;
      forever begin
        @(negedge clk);
        pend_n[g] = exp_q.size();
        if (!rst_n) begin
          p_sck = 1'b0; p_cs = 1'b1; cap = 16'h0000; ld_len = 0; rises_a[g] = 0;
        end else begin
          if (p_cs && !cs[g]) begin
            t_start = cyc; cap = 16'h0000; rises_a[g] = 0;
            if (st_n[g] < MAXF) st_a[g][st_n[g]] = cyc;
            st_n[g]++;
          end
          if (!p_sck && sck[g] && !cs[g]) begin
            cap = {cap[14:0], sdi[g]};
            rises_a[g]++;
          end
          if (!ld[g]) ld_len++;
          if (cs[g]) begin
            checks++;
            if (sdi[g] !== 1'b0 || sck[g] !== 1'b0) begin
              errors++;
              $display("FAIL lane%0d proto_cs_high t=%0t: got sdi=%b sck=%b expected 0 0", g, $time, sdi[g], sck[g]);
            end
          end
          if (!ld[g]) begin
            checks++;
            if (cs[g] !== 1'b1) begin
              errors++;
              $display("FAIL lane%0d proto_ld_cs t=%0t: got cs=%b during LDAC expected 1", g, $time, cs[g]);
            end
          end
          if (!p_cs && cs[g]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL lane%0d sb_frame: got %h with no sample pending expected none", g, cap);
            end else begin
              ef = exp_q.pop_front();
              if (cap !== ef || rises_a[g] != 16) begin
                errors++;
                $display("FAIL lane%0d sb_frame: got %h (%0d rises) expected %h (16 rises)", g, cap, rises_a[g], ef);
              end
            end
            if (got_n[g] < MAXF) begin
              got_a[g][got_n[g]]  = cap;
              rise_a[g][got_n[g]] = rises_a[g];
            end
            got_n[g]++;
            rises_a[g] = 0;
          end
          if (fdone[g]) begin
            if (dn_n[g] < MAXF) begin
              dn_a[g][dn_n[g]]  = cyc;
              dur_a[g][dn_n[g]] = cyc - t_start;
              ld_a[g][dn_n[g]]  = ld_len;
            end
            dn_n[g]++;
            ld_len = 0;
          end
          p_sck = sck[g];
          p_cs  = cs[g];
        end
      end
    end
  end

  // driver tasks: called just after a rising edge; return just after the accepting edge
  task automatic push(input int l, input logic [9:0] d);
    int n;
    n = 0;
    din[l] = d;
    dv[l]  = 1'b1;
    while (rdy[l] !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL push_timeout lane%0d: got ready low for %0d cycles expected accept", l, n);
    end
    @(posedge clk); #1;
    dv[l] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // watchdog
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // stimulus
  initial begin
    logic [9:0] s [6];
    int k, full_at, n;
    s = '{10'h101, 10'h0F0, 10'h3C3, 10'h222, 10'h011, 10'h3FE};
    rst_n  = 1'b0;
    dv     = '0;
    din[0] = 10'h000;
    din[1] = 10'h155;
    idle_cycles(3);
    check("reset_ready",      rdy[0],   1);
    check("reset_cs",         cs[0],    1);
    check("reset_sck",        sck[0],   0);
    check("reset_sdi",        sdi[0],   0);
    check("reset_ld",         ld[0],    1);
    check("reset_busy",       bsy[0],   0);
    check("reset_frame_done", fdone[0], 0);

    // First push accepted on the first edge after release (lane 1, valid held through reset)
    dv[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dv[1] = 1'b0;
    @(posedge clk); #1;
    check("first_push_after_reset_busy", bsy[1], 1);

    // Data wiggling with valid low: nothing may start on lane 0
    repeat (100) begin
      din[0] = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
    end
    check("no_valid_busy",   bsy[0],   0);
    check("no_valid_frames", st_n[0],  0);
    check("lane1_frame",     got_a[1][0], 16'h5554);
    check("lane1_count",     got_n[1], 1);

    // Single full-scale sample
    push(0, 10'h3FF);
    idle_cycles(900);
    check("single_count",    got_n[0],    1);
    check("single_frame",    got_a[0][0], 16'h3FFC);
    check("single_rises",    rise_a[0][0], 16);
    check("single_ld_len",   ld_a[0][0],  25);
    check("single_duration", dur_a[0][0], 875);

    // Back-to-back pair
    push(0, 10'h000);
    push(0, 10'h2AA);
    idle_cycles(1800);
    check("pair_count",  got_n[0],    3);
    check("pair_first",  got_a[0][1], 16'h3000);
    check("pair_second", got_a[0][2], 16'h3AA8);
    check("pair_gap",    st_a[0][2],  dn_a[0][1] + 1);

    // FIFO fill with valid held high
    k = 0; full_at = -1; n = 0;
    din[0] = s[0];
    dv[0]  = 1'b1;
    while (k < 6 && n < 6000) begin
      if (rdy[0]) begin
        @(posedge clk); #1;
        k++;
        if (k < 6) din[0] = s[k];
      end else begin
        if (full_at < 0) full_at = k;
        @(posedge clk); #1;
      end
      n++;
    end
    dv[0] = 1'b0;
    check("fill_accepted_before_full", full_at, 5);
    idle_cycles(4600);
    check("fill_count",   got_n[0],    9);
    check("fill_first",   got_a[0][3], 16'h3404);
    check("fill_last",    got_a[0][8], 16'h3FF8);
    check("fill_drained", pend_n[0],   0);

    // Reset at the 8th SCK rising edge, with two more samples queued behind
    push(0, 10'h2D2);
    push(0, 10'h155);
    push(0, 10'h0AA);
    n = 0;
    while (rises_a[0] < 8 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_mid_reached_8th", rises_a[0], 8);
    rst_n = 1'b0;
    #1;
    check("reset_mid_cs",    cs[0],  1);
    check("reset_mid_sck",   sck[0], 0);
    check("reset_mid_ld",    ld[0],  1);
    check("reset_mid_busy",  bsy[0], 0);
    check("reset_mid_ready", rdy[0], 1);
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1000);
    check("after_reset_busy",   bsy[0],  0);
    check("after_reset_frames", got_n[0], 9);
    check("after_reset_starts", st_n[0], 10);
    check("after_reset_dones",  dn_n[0], 9);

    // Fast divider with random valid traffic
    repeat (1500) begin
      dv[1]  = ($urandom_range(0, 3) != 0);
      din[1] = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
    end
    dv[1] = 1'b0;
    idle_cycles(500);
    check("random_drained",     pend_n[1], 0);
    check("random_many_frames", (got_n[1] > 10), 1);
    check("random_duration",    dur_a[1][1], 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
